gpio_apb_controller: RTL and testbench
======================================

# gpio_apb_controller

256-bit general-purpose I/O block with an APB (v4, zero-wait-state) register slave. Software drives output data and output enables, reads synchronized input pins, and receives a level interrupt on configured input edges. It sits on the peripheral APB bus between the system interconnect and the pad ring.

## Interface
- No parameters; width fixed at 256 GPIOs, 8 × 32-bit words per register bank.
- clk  in  1  single clock for all logic
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- paddr  in  12  APB byte address; bits [1:0] ignored
- pwrite  in  1  1 = write, 0 = read
- psel  in  1  slave select
- penable  in  1  access phase
- pstrb  in  4  write byte strobes; pstrb[i] enables pwdata[8i+7:8i]
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  tied 1
- pslverr  out  1  transfer error
- interrupt  out  1  level interrupt, OR of all enabled pending bits
- gpio_in_data  in  256  pad input values (asynchronous)
- gpio_out_data  out  256  pad output values
- gpio_out_enable  out  256  pad output enables, 1 = drive

## Operation
- Register map (word n = 0..7 covers bits [32n+31:32n], address = base + 4n):
  - 0x000 OUT_DATA  RW  → gpio_out_data
  - 0x100 OUT_EN  RW  → gpio_out_enable
  - 0x200 IN_DATA  RO  synchronized gpio_in_data
  - 0x300 RISE_EN  RW  interrupt on 0→1 of synchronized input
  - 0x380 FALL_EN  RW  interrupt on 1→0 of synchronized input
  - 0x400 INT_STATUS  RW1C  pending edge flags
- Write commits when psel & penable & pwrite, per byte under pstrb.
- Read: prdata = addressed word when psel & !pwrite; 0 otherwise or on unmapped address.
- pslverr = psel & penable & (unmapped address | write to IN_DATA); erroring writes change no state.
- Inputs pass through a 2-flop synchronizer; one further register holds the previous synchronized value for edge detection.
- INT_STATUS[i] sets when an enabled edge occurs on bit i; clears when software writes 1 to it (byte strobed). Simultaneous set and clear on the same bit in the same cycle: set wins.
- interrupt = |INT_STATUS, registered.

## Timing
- Zero wait states: pready = 1 always; every transfer is SETUP + ACCESS = 2 cycles.
- Written registers update on the clk edge ending the ACCESS phase; gpio_out_data and gpio_out_enable change on that edge.
- IN_DATA reflects a pin change 2 clk edges after the change; INT_STATUS sets 1 edge later; interrupt asserts 1 edge after that (4 edges total).
- Reset (async assert, sync deassert upstream): all registers, synchronizers, the edge history, gpio_out_data, gpio_out_enable, INT_STATUS and interrupt are 0; prdata = 0, pslverr = 0. Reset mid-transfer aborts it with no state change.
- The edge history resets to 0, so a pin held high through reset reports a rising edge after reset if RISE_EN is set. No edges are detected while RISE_EN/FALL_EN = 0.

## Test plan
- Reset, write 0x12345678 to 0x000 with pstrb = 0xF → gpio_out_data[31:0] = 0x12345678, all other bits 0, pslverr = 0.
- gpio_in_data = 0x90abcdef_00000000, read 0x204 → prdata = 0x90abcdef, read 0x200 → 0x00000000.
- Write 0xFFFFFFFF to 0x11C with pstrb = 0x3 → gpio_out_enable[255:224] = 0x0000FFFF; readback matches.
- RISE_EN word 0 = 0x1, toggle gpio_in_data[0] 0→1 → interrupt rises within 4 clk; read 0x400 = 0x1; write 0x1 to 0x400 → interrupt = 0.
- Write to 0x200 and read 0x800 → pslverr = 1 in ACCESS phase, read returns 0, IN_DATA unchanged.
- Assert rst during the ACCESS phase of a write → register keeps its reset value of 0 and all outputs are 0.

Source files
------------

// File: rtl/gpio_apb_controller.sv
// 256-bit GPIO block with a zero-wait-state APB register slave.
// Provides output data/enable banks, synchronized inputs and edge interrupts.
module gpio_apb_controller (
    input  logic         clk,
    input  logic         rst,
    input  logic [11:0]  paddr,
    input  logic         pwrite,
    input  logic         psel,
    input  logic         penable,
    input  logic [3:0]   pstrb,
    input  logic [31:0]  pwdata,
    output logic [31:0]  prdata,
    output logic         pready,
    output logic         pslverr,
    output logic         interrupt,
    input  logic [255:0] gpio_in_data,
    output logic [255:0] gpio_out_data,
    output logic [255:0] gpio_out_enable
);

    typedef enum logic [2:0] {
        BankOut,
        BankOen,
        BankIn,
        BankRise,
        BankFall,
        BankStat,
        BankNone
    } bank_e;

    bank_e        bank;
    logic [2:0]   widx;
    logic         access;
    logic         err_cond;
    logic         wr_en;
    logic [255:0] wr_mask;
    logic [255:0] wr_data;
    logic [31:0]  rd_word;
    logic         unused_addr;

    logic [255:0] out_q, out_d;
    logic [255:0] oen_q, oen_d;
    logic [255:0] rise_q, rise_d;
    logic [255:0] fall_q, fall_d;
    logic [255:0] stat_q, stat_d;
    logic [255:0] sync1_q, sync2_q, prev_q;
    logic [255:0] edge_set;
    logic [255:0] stat_clr;
    logic         irq_q;

    assign unused_addr = ^paddr[1:0];
    assign widx        = paddr[4:2];
    assign wr_data     = {8{pwdata}};

    // Each bank spans 8 words (32 bytes), so bits [11:5] select the bank.
    always_comb begin
        bank = BankNone;
        case (paddr[11:5])
            7'h00:   bank = BankOut;
            7'h08:   bank = BankOen;
            7'h10:   bank = BankIn;
            7'h18:   bank = BankRise;
            7'h1C:   bank = BankFall;
            7'h20:   bank = BankStat;
            default: bank = BankNone;
        endcase
    end

    assign access   = psel & penable;
    assign err_cond = (bank == BankNone) | (pwrite & (bank == BankIn));
    assign wr_en    = access & pwrite & ~err_cond;

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < 4; b++) begin
            wr_mask[32 * int'(widx) + 8 * b +: 8] = {8{pstrb[b]}};
        end
    end

    always_comb begin
        out_d  = out_q;
        oen_d  = oen_q;
        rise_d = rise_q;
        fall_d = fall_q;
        if (wr_en && bank == BankOut)  out_d  = (out_q  & ~wr_mask) | (wr_data & wr_mask);
        if (wr_en && bank == BankOen)  oen_d  = (oen_q  & ~wr_mask) | (wr_data & wr_mask);
        if (wr_en && bank == BankRise) rise_d = (rise_q & ~wr_mask) | (wr_data & wr_mask);
        if (wr_en && bank == BankFall) fall_d = (fall_q & ~wr_mask) | (wr_data & wr_mask);
    end

    // A new edge overrides a same-cycle write-1-to-clear.
    assign edge_set = (rise_q & sync2_q & ~prev_q) | (fall_q & ~sync2_q & prev_q);
    assign stat_clr = (wr_en && bank == BankStat) ? (wr_data & wr_mask) : '0;
    assign stat_d   = (stat_q & ~stat_clr) | edge_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            oen_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            stat_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            oen_q   <= oen_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            stat_q  <= stat_d;
            sync1_q <= gpio_in_data;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            irq_q   <= |stat_q;
        end
    end

    always_comb begin
        rd_word = '0;
        case (bank)
            BankOut:  rd_word = out_q[32 * int'(widx) +: 32];
            BankOen:  rd_word = oen_q[32 * int'(widx) +: 32];
            BankIn:   rd_word = sync2_q[32 * int'(widx) +: 32];
            BankRise: rd_word = rise_q[32 * int'(widx) +: 32];
            BankFall: rd_word = fall_q[32 * int'(widx) +: 32];
            BankStat: rd_word = stat_q[32 * int'(widx) +: 32];
            default:  rd_word = '0;
        endcase
    end

    assign prdata          = (psel & ~pwrite & ~rst) ? rd_word : 32'h0;
    assign pslverr         = access & err_cond & ~rst;
    assign pready          = 1'b1;
    assign interrupt       = irq_q;
    assign gpio_out_data   = out_q;
    assign gpio_out_enable = oen_q;

endmodule

// File: tb/tb_gpio_apb_controller.sv
// Self-checking bench for gpio_apb_controller: scoreboarded APB reads plus
// direct checks of pin outputs, interrupt latency, errors and reset abort.
module tb_gpio_apb_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  paddr;
    logic         pwrite;
    logic         psel;
    logic         penable;
    logic [3:0]   pstrb;
    logic [31:0]  pwdata;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;
    logic         interrupt;
    logic [255:0] gpio_in_data;
    logic [255:0] gpio_out_data;
    logic [255:0] gpio_out_enable;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    gpio_apb_controller dut (
        .clk             (clk),
        .rst             (rst),
        .paddr           (paddr),
        .pwrite          (pwrite),
        .psel            (psel),
        .penable         (penable),
        .pstrb           (pstrb),
        .pwdata          (pwdata),
        .prdata          (prdata),
        .pready          (pready),
        .pslverr         (pslverr),
        .interrupt       (interrupt),
        .gpio_in_data    (gpio_in_data),
        .gpio_out_data   (gpio_out_data),
        .gpio_out_enable (gpio_out_enable)
    );

    always #5 clk = ~clk;

    // Full SETUP + ACCESS transfer; rd/err sampled mid ACCESS phase.
    task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        rd  = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pstrb = 0; pwdata = 0;
        gpio_in_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (gpio_out_data !== '0) begin
            errors++; $display("FAIL reset_out_data: got %h want 0", gpio_out_data);
        end
        checks++;
        if (gpio_out_enable !== '0) begin
            errors++; $display("FAIL reset_out_enable: got %h want 0", gpio_out_enable);
        end
        checks++;
        if ({interrupt, pslverr, pready, prdata} !== {3'b001, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got irq=%b err=%b rdy=%b rd=%h want 0 0 1 0",
                     interrupt, pslverr, pready, prdata);
        end
    endtask

    task automatic test_out_data();
        logic [31:0] rd, e;
        logic err;
        apb_xfer(1'b1, 12'h000, 32'h12345678, 4'hF, rd, err);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL out_data_err: got %b want 0", err); end
        checks++;
        if (gpio_out_data !== 256'h12345678) begin
            errors++; $display("FAIL out_data_pins: got %h want 12345678", gpio_out_data);
        end
        exp_q.push_back(32'h12345678);
        apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL out_data_read: got %h want %h", rd, e); end
    endtask

    task automatic test_in_data();
        logic [31:0] rd, e;
        logic err;
        gpio_in_data = 256'h90abcdef_00000000;
        repeat (3) @(posedge clk);
        exp_q.push_back(32'h90abcdef);
        apb_xfer(1'b0, 12'h204, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL in_data_w1: got %h want %h", rd, e); end
        exp_q.push_back(32'h00000000);
        apb_xfer(1'b0, 12'h200, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL in_data_w0: got %h want %h", rd, e); end
    endtask

    task automatic test_out_enable();
        logic [31:0] rd, e;
        logic err;
        apb_xfer(1'b1, 12'h11C, 32'hFFFFFFFF, 4'h3, rd, err);
        checks++;
        if (gpio_out_enable !== {32'h0000FFFF, 224'h0}) begin
            errors++; $display("FAIL out_enable_pins: got %h want 0000ffff<<224", gpio_out_enable);
        end
        exp_q.push_back(32'h0000FFFF);
        apb_xfer(1'b0, 12'h11C, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL out_enable_read: got %h want %h", rd, e); end
    endtask

    task automatic test_interrupt();
        logic [31:0] rd, e;
        logic err;
        int lat;
        apb_xfer(1'b1, 12'h300, 32'h1, 4'hF, rd, err);
        @(posedge clk); #1;
        gpio_in_data[0] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (interrupt && lat == 0) lat = i;
        end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL irq_latency: got %0d edges want 4", lat); end
        exp_q.push_back(32'h1);
        apb_xfer(1'b0, 12'h400, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL irq_status: got %h want %h", rd, e); end
        apb_xfer(1'b1, 12'h400, 32'h1, 4'hF, rd, err);
        @(posedge clk); #1;
        checks++;
        if (interrupt !== 1'b0) begin
            errors++; $display("FAIL irq_clear: got %b want 0", interrupt);
        end
        // Bit 1 rises with its enable clear: no event expected.
        gpio_in_data[1] = 1'b1;
        repeat (5) @(posedge clk);
        exp_q.push_back(32'h0);
        apb_xfer(1'b0, 12'h400, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e || interrupt !== 1'b0) begin
            errors++; $display("FAIL irq_disabled: got %h irq=%b want %h irq=0", rd, interrupt, e);
        end
    endtask

    task automatic test_fall_strobe();
        logic [31:0] rd, e;
        logic err;
        apb_xfer(1'b1, 12'h384, 32'h80000000, 4'hF, rd, err);
        gpio_in_data[63] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL fall_irq: got %b want 1", interrupt); end
        apb_xfer(1'b1, 12'h404, 32'h80000000, 4'h7, rd, err);
        exp_q.push_back(32'h80000000);
        apb_xfer(1'b0, 12'h404, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL fall_unstrobed: got %h want %h", rd, e); end
        apb_xfer(1'b1, 12'h404, 32'h80000000, 4'h8, rd, err);
        exp_q.push_back(32'h0);
        apb_xfer(1'b0, 12'h404, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL fall_strobed_clear: got %h want %h", rd, e); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, e;
        logic err;
        apb_xfer(1'b1, 12'h200, 32'hFFFFFFFF, 4'hF, rd, err);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_ro_write: got %b want 1", err); end
        exp_q.push_back(gpio_in_data[31:0]);
        apb_xfer(1'b0, 12'h200, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e || err !== 1'b0) begin
            errors++; $display("FAIL err_in_data_kept: got %h err=%b want %h err=0", rd, err, e);
        end
        exp_q.push_back(32'h0);
        apb_xfer(1'b0, 12'h800, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e || err !== 1'b1) begin
            errors++; $display("FAIL err_unmapped_800: got %h err=%b want %h err=1", rd, err, e);
        end
        exp_q.push_back(32'h0);
        apb_xfer(1'b0, 12'h020, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e || err !== 1'b1) begin
            errors++; $display("FAIL err_unmapped_020: got %h err=%b want %h err=1", rd, err, e);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] rd, e;
        logic err;
        apb_xfer(1'b1, 12'h000, 32'hDEADBEEF, 4'hF, rd, err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004;
        pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({gpio_out_data, gpio_out_enable, interrupt, pslverr, prdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got out=%h oe=%h irq=%b err=%b rd=%h want all 0",
                     gpio_out_data, gpio_out_enable, interrupt, pslverr, prdata);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.push_back(32'h0);
        apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL reset_mid_word1: got %h want %h", rd, e); end
        exp_q.push_back(32'h0);
        apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, rd, err);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL reset_mid_word0: got %h want %h", rd, e); end
    endtask

    initial begin
        test_reset();
        test_out_data();
        test_in_data();
        test_out_enable();
        test_interrupt();
        test_fall_strobe();
        test_errors();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
